// File: rtl/credit_link_pkg.sv
// rtl/credit_link_pkg.sv - shared types and constants for the credit link sender
package credit_link_pkg;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_SYNC   = 2'd1,
    S_ACTIVE = 2'd2
  } link_state_e;

  // Shared with credit_receiver instantiations so both ends agree on the pool size.
  localparam int DEFAULT_MAX_CREDITS = 4;

  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
    return s[IDX_W-1:0];
  endfunction

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_idx(ptr, k);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/credit_link_arbiter.sv
// rtl/credit_link_arbiter.sv - round-robin sender sharing one credit-based link
module credit_link_arbiter
  import credit_link_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_CREDITS = DEFAULT_MAX_CREDITS,
  parameter int CREDIT_W    = credit_width(MAX_CREDITS),
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      push_valid,
  output logic [DATA_W-1:0]         push_data,
  input  logic                      push_credit,
  output logic                      push_credit_stall,
  input  logic                      cfg_credit_stall,
  output logic                      push_sender_in_reset,
  input  logic                      push_receiver_in_reset,
  output logic [CREDIT_W-1:0]       credit_count,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      credit_overflow
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_CREDITS);

  link_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                push_valid_q, push_valid_d;
  logic [DATA_W-1:0]   push_data_q, push_data_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                overflow_q, overflow_d;

  logic                arb_en;
  logic                accept;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;

  // Only the registered count gates a grant, so a same-cycle return cannot fund a beat.
  assign arb_en = (state_q == S_ACTIVE) && !push_receiver_in_reset && (credit_q != '0);
  assign accept = |arb_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .en    (arb_en),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    push_valid_d = 1'b0;
    push_data_d  = push_data_q;
    grant_idx_d  = grant_idx_q;
    rr_ptr_d     = rr_ptr_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      S_RESET: begin
        state_d  = S_SYNC;
        credit_d = '0;
      end
      S_SYNC: begin
        credit_d = '0;
        if (!push_receiver_in_reset) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (push_receiver_in_reset) begin
          state_d  = S_SYNC;
          credit_d = '0;
        end else if (push_credit && !accept) begin
          if (credit_q == CREDIT_MAX) overflow_d = 1'b1;
          else                        credit_d   = credit_q + 1'b1;
        end else if (accept && !push_credit) begin
          credit_d = credit_q - 1'b1;
        end
      end
      default: state_d = S_RESET;
    endcase

    if (accept) begin
      push_valid_d = 1'b1;
      push_data_d  = req_data[arb_idx*DATA_W +: DATA_W];
      grant_idx_d  = arb_idx;
      rr_ptr_d     = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RESET;
      credit_q     <= '0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      grant_idx_q  <= '0;
      rr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      grant_idx_q  <= grant_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      overflow_q   <= overflow_d;
    end
  end

  assign req_ready            = arb_grant;
  assign push_valid           = push_valid_q;
  assign push_data            = push_data_q;
  assign credit_count         = credit_q;
  assign grant_idx            = grant_idx_q;
  assign credit_overflow      = overflow_q;
  assign push_sender_in_reset = (state_q != S_ACTIVE);
  assign push_credit_stall    = cfg_credit_stall || (credit_q == CREDIT_MAX) || (state_q != S_ACTIVE);

endmodule

// File: doc/credit_link_arbiter.md
Name: credit_link_arbiter

Overview:
- Sender-side controller that shares one credit-based link among NUM_REQ requesters.
- Round-robin arbitrates requester valid/ready streams onto a single push_valid/push_data channel toward a credit_receiver.
- Tracks link credits: consumes one per beat, regains one per returned push_credit.
- Sequences the sender/receiver reset handshake so no beat is sent without a credit.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 8, beat width
- MAX_CREDITS, 4, credit counter ceiling (≥1)
- CREDIT_W, $clog2(MAX_CREDITS+1), derived credit counter width

Ports:
- clk  input  1  clock
- rst  input  1  reset, one clock; reset is asynchronous and active-low
- req_valid  input  NUM_REQ  per-requester beat valid
- req_data  input  NUM_REQ*DATA_W  per-requester beat, requester i at [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant; beat accepted when req_valid[i]&req_ready[i]
- push_valid  output  1  registered beat valid to receiver
- push_data  output  DATA_W  registered beat data
- push_credit  input  1  credit return from receiver, one credit per cycle high
- push_credit_stall  output  1  asks receiver to withhold credit returns
- cfg_credit_stall  input  1  software request to stall credit returns
- push_sender_in_reset  output  1  sender is in reset/sync
- push_receiver_in_reset  input  1  receiver is in reset
- credit_count  output  CREDIT_W  current credits held
- grant_idx  output  $clog2(NUM_REQ)  index of last granted requester
- credit_overflow  output  1  sticky error flag

Behaviour:
- Reset values while rst low: state=RESET, credit_count=0, push_valid=0, push_data=0, req_ready=0, push_sender_in_reset=1, grant_idx=0, rr pointer=0, credit_overflow=0.
- FSM states: RESET, SYNC, ACTIVE.
- RESET → SYNC on the first clk after rst deasserts. push_sender_in_reset stays 1 in RESET and SYNC and is 0 only in ACTIVE.
- SYNC → ACTIVE when push_receiver_in_reset=0. SYNC is held while it is 1.
- In SYNC, credit_count is forced to 0 and push_credit is ignored.
- ACTIVE → SYNC when push_receiver_in_reset=1:
  - Same cycle: req_ready=0.
  - Next edge: credit_count=0 and push_valid=0.
  - A beat already registered in push_valid is still presented for that one cycle. The receiver drops it.
- Arbitration, ACTIVE only, combinational:
  - Eligible when credit_count>0 (after counting this cycle's push_credit is not allowed; use registered credit_count only).
  - Winner is the first i with req_valid[i]=1, searching from the rr pointer upward and wrapping at NUM_REQ.
  - req_ready is one-hot at the winner and all-zero when not eligible or no valid.
- On accept, next edge:
  - push_valid=1, push_data=req_data[winner].
  - grant_idx=winner, rr pointer=(winner+1) mod NUM_REQ.
  - Otherwise push_valid=0 and push_data holds.
- Latency: one cycle from accept to push_valid. Throughput is one beat per cycle while credits are non-zero.
- Credit arithmetic, ACTIVE:
  - next = credit_count + push_credit − accept.
  - Simultaneous return and consume leaves the count unchanged.
  - Consume is impossible at 0 because it is gated.
  - A return while credit_count=MAX_CREDITS with no consume saturates at MAX_CREDITS and sets credit_overflow. credit_overflow is sticky until rst.
- push_credit_stall = cfg_credit_stall | (credit_count==MAX_CREDITS) | (state!=ACTIVE), combinational.
- Requester must hold req_valid/req_data until accepted. The rr pointer does not advance without an accept.

Decomposition:
- Package credit_link_pkg holds:
  - the state enum (RESET, SYNC, ACTIVE)
  - a credit width helper function
  - the default MAX_CREDITS constant shared with credit_receiver instantiations
- One sub-module, rr_arbiter:
  - inputs: request vector, pointer, enable
  - output: one-hot grant and index
  - purely combinational, parameterised on NUM_REQ.
- Credit counter and FSM stay in the top.

Test Plan:
- Reset/sync: hold push_receiver_in_reset=1 for 5 cycles after rst release → push_sender_in_reset=1, req_ready=0, credit_count=0. Drop it → ACTIVE next edge, push_sender_in_reset=0.
- Credit gating: ACTIVE, 0 credits, req_valid=4'b0001 → req_ready=0. Pulse push_credit 2 cycles → credit_count=2, two beats accepted back to back, then credit_count=0 and req_ready=0.
- Round-robin: credits=4, req_valid=4'b1111 constant, data=i → push_data order 0,1,2,3. With req_valid=4'b1010 after granting 1 → next grant 3, then 1.
- Simultaneous: credit_count=1, push_credit=1 and an accept in the same cycle → credit_count stays 1 and push_valid=1 next cycle.
- Saturation/stall: MAX_CREDITS=4, five returns with no traffic → credit_count=4, credit_overflow=1, push_credit_stall=1 from the cycle count reaches 4.
- Receiver reset mid-stream: credits=3, streaming, then assert push_receiver_in_reset → req_ready=0 same cycle, credit_count=0 next edge, state SYNC. Async rst low mid-beat → all outputs at reset values immediately.
